universal_bin_cnt_seq: RTL and testbench
========================================

UNIVERSAL_BIN_CNT_SEQ -- requirements
Module: universal_bin_cnt_seq

Interface
REQ-001 The block SHALL have parameter N, default 5, setting the counter width; all count/value ports are N bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: command request.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: command accepted when cmd_valid && cmd_ready.
REQ-006 The block SHALL have port cmd_mode, input, 2 bits: 00 one-shot up, 01 one-shot down, 10 periodic up, 11 periodic down.
REQ-007 The block SHALL have port cmd_start, input, N bits: load value.
REQ-008 The block SHALL have port cmd_term, input, N bits: terminal value.
REQ-009 The block SHALL have port abort, input, 1 bit: cancel the active command.
REQ-010 The block SHALL have port cnt_q, input, N bits: counter output fed back from the counter.
REQ-011 The block SHALL have ports cnt_syn_clr, cnt_load, cnt_en and cnt_up, outputs, 1 bit each: counter controls.
REQ-012 The block SHALL have port cnt_d, output, N bits: counter load data.
REQ-013 The block SHALL have ports busy (state != IDLE), done (one-shot completion pulse) and tc (periodic terminal pulse), outputs, 1 bit each.
REQ-014 The block SHALL have port wrap_cnt, output, 8 bits: number of periodic reloads.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, RUN, DONE and ABORT.
REQ-016 cmd_ready SHALL be 1 only in IDLE; cmd_valid outside IDLE SHALL be ignored.
REQ-017 On accept, mode/start/term SHALL be registered, wrap_cnt cleared, next state LOAD.
REQ-018 In LOAD: cnt_load=1, cnt_d=start, cnt_en=0, cnt_up=direction (mode[0]==0 -> up); next state RUN.
REQ-019 In RUN with cnt_q != term: cnt_en=1, cnt_load=0, cnt_up=direction.
REQ-020 In RUN with cnt_q == term, one-shot: cnt_en=0; next state DONE.
REQ-021 In RUN with cnt_q == term, periodic: cnt_load=1, cnt_d=start, cnt_en=0, wrap_cnt+1 (255 wraps to 0), tc=1 next cycle; stay in RUN.
REQ-022 In DONE: done=1 for exactly one cycle; next state IDLE.
REQ-023 Abort in LOAD or RUN SHALL take priority over terminal detection; next state ABORT, with no done or tc for that cycle.
REQ-024 In ABORT: cnt_syn_clr=1 for one cycle; next state IDLE.
REQ-025 Abort in IDLE or DONE SHALL be ignored.
REQ-026 Counting SHALL be modulo 2^N: count steps = (term-start) mod 2^N for up and (start-term) mod 2^N for down; a "wrong-direction" term wraps through 0 or 2^N-1.
REQ-027 start == term: one-shot SHALL reach DONE with zero count steps; periodic SHALL reload and pulse tc every RUN cycle.
REQ-028 Outside the states listed above, cnt_syn_clr, cnt_load and cnt_en SHALL be 0; cnt_d SHALL hold the registered start.
REQ-029 Accept-to-done latency SHALL be steps+3 cycles (LOAD, steps+1 RUN cycles, DONE).

Reset
REQ-030 While rst=0: state IDLE, cmd_ready=1, busy=0, done=0, tc=0, wrap_cnt=0, all cnt_* outputs 0, cnt_d=0, and registered mode/start/term = 0.
REQ-031 Reset assertion mid-operation SHALL abandon the command immediately, without a cnt_syn_clr pulse; the first cycle after release SHALL be IDLE.

Verification
REQ-032 One-shot up, start=2, term=5, accepted at cycle 0 -> cnt_load at c1; cnt_q 2,3,4,5 at c2..c5; cnt_en=0 at c5; done at c6; cmd_ready at c7.
REQ-033 One-shot down, start=20, term=17 -> three cnt_en cycles, cnt_up=0 throughout, single done pulse.
REQ-034 Periodic up, start=30, term=1 (N=5) -> cnt_q 30,31,0,1 then reload to 30; tc each period; wrap_cnt increments per reload.
REQ-035 Abort at the same cycle cnt_q==term -> no done/tc, one cnt_syn_clr pulse, IDLE next.
REQ-036 start == term, both modes -> immediate done (one-shot) or tc every cycle (periodic); cmd_valid held while busy is not accepted.
REQ-037 rst=0 asserted during RUN -> all outputs at reset values within the same cycle; a new command is accepted after release.

Source files
------------

// File: rtl/universal_bin_cnt_seq.sv
// Command sequencer for an external up/down binary counter: loads a start value,
// runs to a terminal value in one-shot or periodic mode, supports abort.
module universal_bin_cnt_seq #(
  parameter int unsigned N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_mode,
  input  logic [N-1:0] cmd_start,
  input  logic [N-1:0] cmd_term,
  input  logic         abort,
  input  logic [N-1:0] cnt_q,
  output logic         cnt_syn_clr,
  output logic         cnt_load,
  output logic         cnt_en,
  output logic         cnt_up,
  output logic [N-1:0] cnt_d,
  output logic         busy,
  output logic         done,
  output logic         tc,
  output logic [7:0]   wrap_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DONE,
    ABORT
  } state_e;

  state_e       state_q;
  logic [1:0]   mode_q;
  logic [N-1:0] start_q;
  logic [N-1:0] term_q;
  logic [7:0]   wrap_q;
  logic         tc_q;
  logic         done_q;
  logic         busy_q;
  logic         ready_q;

  logic hit;
  logic periodic;
  logic dir_up;
  logic reload;
  logic finish;

  assign hit      = (cnt_q == term_q);
  assign periodic = mode_q[1];
  assign dir_up   = ~mode_q[0];

  // Counter strobes follow the fed-back count in the same cycle, so they are
  // decoded combinationally; abort suppresses them ahead of terminal detection.
  always_comb begin
    cnt_syn_clr = 1'b0;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;
    cnt_up      = 1'b0;
    reload      = 1'b0;
    finish      = 1'b0;
    case (state_q)
      LOAD: begin
        if (!abort) begin
          cnt_load = 1'b1;
          cnt_up   = dir_up;
        end
      end
      RUN: begin
        if (!abort) begin
          cnt_up = dir_up;
          if (!hit) begin
            cnt_en = 1'b1;
          end else if (periodic) begin
            cnt_load = 1'b1;
            reload   = 1'b1;
          end else begin
            finish = 1'b1;
          end
        end
      end
      ABORT: cnt_syn_clr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      start_q <= '0;
      term_q  <= '0;
      wrap_q  <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      tc_q   <= reload;
      done_q <= 1'b0;
      if (reload) begin
        wrap_q <= wrap_q + 8'd1;
      end
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            mode_q  <= cmd_mode;
            start_q <= cmd_start;
            term_q  <= cmd_term;
            wrap_q  <= '0;
            state_q <= LOAD;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        LOAD: state_q <= abort ? ABORT : RUN;
        RUN: begin
          if (abort) begin
            state_q <= ABORT;
          end else if (finish) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tc        = tc_q;
  assign wrap_cnt  = wrap_q;
  assign cnt_d     = start_q;

endmodule

// File: tb/tb_universal_bin_cnt_seq.sv
// Scoreboard bench: a counter model closes the loop; expected done/tc/clear
// events are derived from step arithmetic and checked by a monitor.
module tb_universal_bin_cnt_seq;
  localparam int N = 5;
  localparam int M = 1 << N;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_mode = '0;
  logic [N-1:0] cmd_start = '0;
  logic [N-1:0] cmd_term = '0;
  logic         abort = 1'b0;
  logic [N-1:0] cnt_q = '0;
  logic         cnt_syn_clr, cnt_load, cnt_en, cnt_up;
  logic [N-1:0] cnt_d;
  logic         busy, done, tc;
  logic [7:0]   wrap_cnt;

  always #5 clk = ~clk;

  universal_bin_cnt_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_start(cmd_start), .cmd_term(cmd_term),
    .abort(abort), .cnt_q(cnt_q), .cnt_syn_clr(cnt_syn_clr),
    .cnt_load(cnt_load), .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_d(cnt_d),
    .busy(busy), .done(done), .tc(tc), .wrap_cnt(wrap_cnt)
  );

  // External counter driven by the sequencer
  always @(posedge clk) begin
    if (cnt_syn_clr)   cnt_q <= '0;
    else if (cnt_load) cnt_q <= cnt_d;
    else if (cnt_en)   cnt_q <= cnt_up ? cnt_q + 1'b1 : cnt_q - 1'b1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int c;
    int kind;   // 4 done, 2 tc, 1 counter clear
    int wrap;
    int cnt;    // expected cnt_q at the event, -1 when not checked
  } ev_t;
  ev_t exp_q[$];

  bit cur_up = 1'b1;
  int cur_start = 0;

  function automatic void check(string name, int got, int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endfunction

  function automatic void push_ev(int c, int kind, int wrap, int cnt);
    ev_t e;
    e.c = c; e.kind = kind; e.wrap = wrap; e.cnt = cnt;
    exp_q.push_back(e);
  endfunction

  function automatic int steps_of(int mode, int s, int t);
    return ((mode % 2) == 0) ? (t - s + M) % M : (s - t + M) % M;
  endfunction

  always @(negedge clk) begin : monitor
    int k;
    ev_t e;
    if (rst) begin
      k = {29'd0, done, tc, cnt_syn_clr};
      if (k != 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", k, 0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", k, e.kind);
          check("event_cycle", cyc, e.c);
          if (e.kind == 2) check("wrap_cnt", int'(wrap_cnt), e.wrap);
          if (e.cnt >= 0)  check("cnt_at_event", int'(cnt_q), e.cnt);
        end
      end
      check("busy_vs_ready", int'(busy), int'(!cmd_ready));
      if (cnt_en)   check("cnt_up_dir", int'(cnt_up), int'(cur_up));
      if (cnt_load) check("cnt_d_start", int'(cnt_d), cur_start);
    end
  end

  task automatic check_reset_vals(string name);
    check({name, "_ctl"}, int'({cmd_ready, busy, done, tc, cnt_syn_clr, cnt_load, cnt_en, cnt_up}), 8'h80);
    check({name, "_wrap"}, int'(wrap_cnt), 0);
    check({name, "_cnt_d"}, int'(cnt_d), 0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      failures++;
      $display("FAIL ready_timeout: cmd_ready never returned (cycle %0d)", cyc);
      $fatal(1, "sequencer stuck");
    end
  endtask

  // Issue one command at the current drive point; d = cycles after accept
  // at which abort is pulsed (0 = none).
  task automatic run_cmd(input int mode, input int s, input int t, input int d,
                         input bit hold, input bit idle_ab);
    int a, steps, idle_c;
    bit per;
    wait_ready();
    per   = (mode >= 2);
    steps = steps_of(mode, s, t);
    a     = cyc;
    cmd_valid = 1'b1;
    cmd_mode  = 2'(mode);
    cmd_start = N'(s);
    cmd_term  = N'(t);
    abort     = idle_ab;
    cur_up    = ((mode % 2) == 0);
    cur_start = s;
    if (!per) begin
      if (d >= 1 && d <= steps + 2) begin
        push_ev(a + d + 1, 1, 0, -1);
        idle_c = a + d + 2;
      end else begin
        push_ev(a + steps + 3, 4, 0, t);
        idle_c = a + steps + 4;
      end
    end else begin
      for (int k = 1; 2 + k * (steps + 1) <= d; k++)
        push_ev(a + 2 + k * (steps + 1), 2, k % 256, s);
      push_ev(a + d + 1, 1, 0, -1);
      idle_c = a + d + 2;
    end
    while (cyc < idle_c) begin
      @(posedge clk); #1;
      cmd_valid = hold;
      cmd_mode  = 2'($urandom);
      cmd_start = N'($urandom);
      cmd_term  = N'($urandom);
      abort     = (d > 0 && cyc == a + d);
      if (cyc == idle_c - 1) check("ready_low_before_idle", int'(cmd_ready), 0);
    end
    check("ready_at_idle", int'(cmd_ready), 1);
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic reset_phase();
    int a;
    wait_ready();
    a = cyc;
    cmd_valid = 1'b1;
    cmd_mode  = 2'd2;
    cmd_start = N'(3);
    cmd_term  = N'(10);
    cur_up    = 1'b1;
    cur_start = 3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    while (cyc < a + 6) begin
      @(posedge clk); #1;
    end
    check("busy_before_reset", int'(busy), 1);
    rst = 1'b0;
    #1;
    check_reset_vals("reset_mid_run");
    repeat (2) begin
      @(posedge clk); #1;
    end
    check_reset_vals("reset_held");
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_after_release", int'({cmd_ready, busy}), 2);
    run_cmd(0, 1, 4, 0, 0, 0);
  endtask

  initial begin
    int mode, s, t, d, steps;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset_init");
    rst = 1'b1;
    @(posedge clk); #1;

    run_cmd(0, 2, 5, 0, 0, 0);     // one-shot up
    run_cmd(1, 20, 17, 0, 1, 0);   // one-shot down, valid held while busy
    run_cmd(2, 30, 1, 14, 0, 0);   // periodic up through 0
    run_cmd(0, 2, 5, 5, 0, 0);     // abort on terminal cycle
    run_cmd(3, 8, 6, 7, 0, 0);     // periodic down, abort on terminal cycle
    run_cmd(0, 7, 7, 0, 1, 0);     // start == term one-shot
    run_cmd(2, 9, 9, 300, 1, 0);   // tc every cycle, wrap_cnt rolls past 255
    run_cmd(1, 9, 9, 1, 0, 1);     // abort in LOAD, abort in IDLE ignored
    run_cmd(0, 5, 2, 0, 0, 0);     // wrong-direction terms
    run_cmd(1, 2, 5, 0, 0, 0);
    run_cmd(0, 2, 5, 6, 0, 0);     // abort in DONE ignored
    reset_phase();

    for (int i = 0; i < 40; i++) begin
      mode  = int'($urandom_range(0, 3));
      s     = int'($urandom_range(0, M - 1));
      t     = ($urandom_range(0, 7) == 0) ? s : int'($urandom_range(0, M - 1));
      steps = steps_of(mode, s, t);
      if (mode < 2) d = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, steps + 3));
      else          d = int'($urandom_range(1, 3 * (steps + 1) + 2));
      run_cmd(mode, s, t, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
